// File: rtl/l2_icache_resp.sv
// ---------------------------------------------------------------------------
// l2_icache_resp
//   L2-side responder for instruction-cache refill requests. A single block
//   request (irq + l2_addr) is looked up in an external direct-mapped L2
//   tag/data array. A hit returns the stored block with an l2_rdy pulse. A
//   miss fetches the block from memory, writes it into L2 and forwards it with
//   an mem_wr_ic_en pulse. Every transaction, including an unsupported WRITE
//   request, ends with a one-cycle complete pulse.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   irq, l2_addr,       icache request, block address, 0=READ / 1=WRITE
//   l2_cache_rw
//   l2_busy             high in every state except IDLE
//   l2_rdy              hit block valid on data_wd_l2 (1-cycle pulse)
//   mem_wr_ic_en        miss-fill block valid on data_wd_l2 (1-cycle pulse)
//   data_wd_l2          registered block to the icache, held until next load
//   complete            transaction done (1-cycle pulse)
//   l2_index            L2 array index, taken from the accepted address
//   l2_tag_rd/l2_data_rd  {valid, tag} and block read from the L2 array
//   l2_rw, l2_tag_wd,   L2 array write strobe and fill tag/block
//   l2_data_wd
//   mem_req, mem_addr   memory read request (held until mem_rdy) and address
//   mem_rdy, mem_data   memory block return
//
// Configuration
//   L2_RESP_STAT_EN  adds saturating 32-bit hit_cnt / miss_cnt outputs.
// ---------------------------------------------------------------------------
module l2_icache_resp #(
  parameter int ADDR_W = 28,
  parameter int IDX_W  = 9,
  parameter int BLK_W  = 128,
  localparam int TAG_W = ADDR_W - IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              irq,
  input  logic [ADDR_W-1:0] l2_addr,
  input  logic              l2_cache_rw,
  output logic              l2_busy,
  output logic              l2_rdy,
  output logic              mem_wr_ic_en,
  output logic [BLK_W-1:0]  data_wd_l2,
  output logic              complete,
  output logic [IDX_W-1:0]  l2_index,
  input  logic [TAG_W:0]    l2_tag_rd,
  input  logic [BLK_W-1:0]  l2_data_rd,
  output logic              l2_rw,
  output logic [TAG_W:0]    l2_tag_wd,
  output logic [BLK_W-1:0]  l2_data_wd,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rdy,
  input  logic [BLK_W-1:0]  mem_data
`ifdef L2_RESP_STAT_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_L2_RD,
    S_HIT_SEND,
    S_MEM_REQ,
    S_MEM_FWD,
    S_DONE
  } state_t;

  state_t            state, next_state;
  logic [ADDR_W-1:0] req_addr;
  logic [TAG_W-1:0]  req_tag;
  logic              tag_hit;
  logic              accept;

  assign req_tag  = req_addr[ADDR_W-1:IDX_W];
  assign l2_index = req_addr[IDX_W-1:0];
  assign mem_addr = req_addr;

  // The array read launched by the index held in req_addr is compared while
  // in L2_RD; a cleared valid bit never hits, whatever the stored tag.
  assign tag_hit = l2_tag_rd[TAG_W] && (l2_tag_rd[TAG_W-1:0] == req_tag);
  assign accept  = (state == S_IDLE) && irq;

  // Fill write-back is only driven while the strobe is up so the array sees
  // quiet buses the rest of the time.
  assign l2_tag_wd  = l2_rw ? {1'b1, req_tag} : '0;
  assign l2_data_wd = l2_rw ? mem_data : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      req_addr   <= '0;
      data_wd_l2 <= '0;
    end else begin
      state <= next_state;
      if (accept) req_addr <= l2_addr;
      if (state == S_L2_RD && tag_hit)
        data_wd_l2 <= l2_data_rd;
      else if (state == S_MEM_REQ && mem_rdy)
        data_wd_l2 <= mem_data;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    next_state   = state;
    l2_busy      = 1'b1;
    l2_rdy       = 1'b0;
    mem_wr_ic_en = 1'b0;
    complete     = 1'b0;
    mem_req      = 1'b0;
    l2_rw        = 1'b0;
    unique case (state)
      S_IDLE: begin
        l2_busy = 1'b0;
        // WRITE is unsupported: it skips the array and only completes.
        if (irq) next_state = l2_cache_rw ? S_DONE : S_L2_RD;
      end
      S_L2_RD:    next_state = tag_hit ? S_HIT_SEND : S_MEM_REQ;
      S_HIT_SEND: begin
        l2_rdy     = 1'b1;
        next_state = S_DONE;
      end
      S_MEM_REQ: begin
        mem_req = 1'b1;
        // Fill L2 in the same cycle the memory block arrives.
        if (mem_rdy) begin
          l2_rw      = 1'b1;
          next_state = S_MEM_FWD;
        end
      end
      S_MEM_FWD: begin
        mem_wr_ic_en = 1'b1;
        next_state   = S_DONE;
      end
      S_DONE: begin
        // irq is not looked at here; a held irq is taken in the next IDLE.
        complete   = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

`ifdef L2_RESP_STAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == S_L2_RD) begin
      if (tag_hit) begin
        if (hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
      end else begin
        if (miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_l2_icache_resp.sv
// ---------------------------------------------------------------------------
// tb_l2_icache_resp
//   Directed bench for l2_icache_resp: a table of single transactions with
//   hand-computed outcomes, plus hand-written sequences for reset during a
//   memory fetch and back-to-back requests. Inputs change and outputs are
//   sampled just after the falling edge.
// ---------------------------------------------------------------------------
module tb_l2_icache_resp;

  localparam int ADDR_W = 28;
  localparam int IDX_W  = 9;
  localparam int BLK_W  = 128;
  localparam int TAG_W  = ADDR_W - IDX_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              irq;
  logic [ADDR_W-1:0] l2_addr;
  logic              l2_cache_rw;
  logic              l2_busy;
  logic              l2_rdy;
  logic              mem_wr_ic_en;
  logic [BLK_W-1:0]  data_wd_l2;
  logic              complete;
  logic [IDX_W-1:0]  l2_index;
  logic [TAG_W:0]    l2_tag_rd;
  logic [BLK_W-1:0]  l2_data_rd;
  logic              l2_rw;
  logic [TAG_W:0]    l2_tag_wd;
  logic [BLK_W-1:0]  l2_data_wd;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rdy;
  logic [BLK_W-1:0]  mem_data;
`ifdef L2_RESP_STAT_EN
  logic [31:0]       hit_cnt;
  logic [31:0]       miss_cnt;
`endif

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int exp_hits = 0;
  int exp_miss = 0;

  always #5 clk = ~clk;

  l2_icache_resp dut (
    .clk          (clk),
    .rst          (rst),
    .irq          (irq),
    .l2_addr      (l2_addr),
    .l2_cache_rw  (l2_cache_rw),
    .l2_busy      (l2_busy),
    .l2_rdy       (l2_rdy),
    .mem_wr_ic_en (mem_wr_ic_en),
    .data_wd_l2   (data_wd_l2),
    .complete     (complete),
    .l2_index     (l2_index),
    .l2_tag_rd    (l2_tag_rd),
    .l2_data_rd   (l2_data_rd),
    .l2_rw        (l2_rw),
    .l2_tag_wd    (l2_tag_wd),
    .l2_data_wd   (l2_data_wd),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_rdy      (mem_rdy),
    .mem_data     (mem_data)
`ifdef L2_RESP_STAT_EN
    ,
    .hit_cnt      (hit_cnt),
    .miss_cnt     (miss_cnt)
`endif
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              rw;
    logic [TAG_W:0]    tag_rd;
    logic [BLK_W-1:0]  data_rd;
    int                mem_delay;  // MEM_REQ cycles before mem_rdy
    logic [BLK_W-1:0]  mem_blk;
    logic              exp_hit;
    logic [BLK_W-1:0]  exp_blk;    // data_wd_l2 once the block is delivered
  } vec_t;

  localparam logic [BLK_W-1:0] GARBAGE = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;

  task automatic check(input string name, input logic [BLK_W-1:0] act,
                       input logic [BLK_W-1:0] exp);
    chk_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    else
      pass_cnt++;
  endtask

  task automatic check_pulses(input string nm, input logic rdy, input logic wr,
                              input logic cmp, input logic mreq, input logic busy);
    check({nm, ".l2_rdy"},       BLK_W'(l2_rdy),       BLK_W'(rdy));
    check({nm, ".mem_wr_ic_en"}, BLK_W'(mem_wr_ic_en), BLK_W'(wr));
    check({nm, ".complete"},     BLK_W'(complete),     BLK_W'(cmp));
    check({nm, ".mem_req"},      BLK_W'(mem_req),      BLK_W'(mreq));
    check({nm, ".l2_busy"},      BLK_W'(l2_busy),      BLK_W'(busy));
  endtask

  // Runs one transaction starting in an IDLE cycle. Unless keep_irq is set,
  // irq drops right after acceptance to show the transaction still finishes.
  task automatic run_txn(input vec_t v, input bit keep_irq, input string nm);
    @(negedge clk);
    irq = 1'b1; l2_addr = v.addr; l2_cache_rw = v.rw;
    l2_tag_rd = v.tag_rd; l2_data_rd = v.data_rd;
    mem_rdy = 1'b0; mem_data = GARBAGE;
    #1 check({nm, ".idle_busy"}, BLK_W'(l2_busy), '0);

    @(negedge clk);
    if (!keep_irq) irq = 1'b0;
    l2_addr = ~v.addr; l2_cache_rw = ~v.rw;  // must not disturb the request
    #1;
    if (v.rw) begin
      check_pulses({nm, ".wr_done"}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      check({nm, ".wr_l2_rw"}, BLK_W'(l2_rw), '0);
      check({nm, ".wr_hold"}, data_wd_l2, v.exp_blk);
      return;
    end
    check_pulses({nm, ".l2rd"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check({nm, ".l2_index"}, BLK_W'(l2_index), BLK_W'(v.addr[IDX_W-1:0]));

    if (v.exp_hit) begin
      @(negedge clk); #1;
      check_pulses({nm, ".hit_send"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      check({nm, ".hit_data"}, data_wd_l2, v.exp_blk);
    end else begin
      for (int d = 0; d < v.mem_delay; d++) begin
        @(negedge clk); #1;
        check_pulses({nm, ".mem_wait"}, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check({nm, ".mem_addr"}, BLK_W'(mem_addr), BLK_W'(v.addr));
        check({nm, ".wait_l2_rw"}, BLK_W'(l2_rw), '0);
      end
      @(negedge clk);
      mem_rdy = 1'b1; mem_data = v.mem_blk;
      #1;
      check({nm, ".fill_mem_req"}, BLK_W'(mem_req), BLK_W'(1'b1));
      check({nm, ".fill_l2_rw"}, BLK_W'(l2_rw), BLK_W'(1'b1));
      check({nm, ".fill_tag"}, BLK_W'(l2_tag_wd), BLK_W'({1'b1, v.addr[ADDR_W-1:IDX_W]}));
      check({nm, ".fill_data"}, l2_data_wd, v.mem_blk);
      check({nm, ".fill_index"}, BLK_W'(l2_index), BLK_W'(v.addr[IDX_W-1:0]));
      @(negedge clk);
      mem_rdy = 1'b0; mem_data = GARBAGE;
      #1;
      check_pulses({nm, ".mem_fwd"}, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      check({nm, ".fwd_data"}, data_wd_l2, v.exp_blk);
      check({nm, ".fwd_l2_rw"}, BLK_W'(l2_rw), '0);
    end

    @(negedge clk); #1;
    check_pulses({nm, ".done"}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check({nm, ".done_hold"}, data_wd_l2, v.exp_blk);
  endtask

  vec_t vecs[7];

  initial begin
    rst = 1'b1; irq = 1'b0; l2_addr = '0; l2_cache_rw = 1'b0;
    l2_tag_rd = '0; l2_data_rd = '0; mem_rdy = 1'b0; mem_data = '0;

    //            addr          rw    tag_rd       data_rd  dly mem_blk        hit   exp_blk
    vecs[0] = '{28'h000_0123, 1'b0, 20'h00000, GARBAGE, 5, {16{8'hA5}},   1'b0, {16{8'hA5}}};
    vecs[1] = '{28'h000_0123, 1'b0, 20'h80000,
                128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 0, GARBAGE, 1'b1,
                128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210};
    // index 9'h123, tag 19'h1 vs stored tag 19'h0
    vecs[2] = '{28'h000_0323, 1'b0, 20'h80000, GARBAGE, 2, {8{16'h1122}}, 1'b0, {8{16'h1122}}};
    // index 9'h123, tag 19'h0 vs stored tag 19'h1; memory answers at once
    vecs[3] = '{28'h000_0123, 1'b0, 20'h80001, GARBAGE, 0, {4{32'h3C3C_0F0F}}, 1'b0, {4{32'h3C3C_0F0F}}};
    // unsupported WRITE: no data, previous block stays on data_wd_l2
    vecs[4] = '{28'h000_0777, 1'b1, 20'h80000, GARBAGE, 0, GARBAGE, 1'b0, {4{32'h3C3C_0F0F}}};
    vecs[5] = '{28'hFFF_FFFF, 1'b0, 20'hFFFFF, {2{64'hCAFE_F00D_1234_5678}}, 0, GARBAGE, 1'b1,
                {2{64'hCAFE_F00D_1234_5678}}};
    // stored tag matches but entry is invalid
    vecs[6] = '{28'h000_0123, 1'b0, 20'h00000, GARBAGE, 1, {16{8'h5A}}, 1'b0, {16{8'h5A}}};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_pulses("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset.data_wd_l2", data_wd_l2, '0);
    check("reset.l2_rw", BLK_W'(l2_rw), '0);
    check("reset.l2_index", BLK_W'(l2_index), '0);
`ifdef L2_RESP_STAT_EN
    check("reset.hit_cnt", BLK_W'(hit_cnt), '0);
    check("reset.miss_cnt", BLK_W'(miss_cnt), '0);
`endif

    // Reset while waiting on memory: the late mem_rdy must be ignored.
    @(negedge clk);
    irq = 1'b1; l2_addr = 28'h000_0456; l2_tag_rd = '0;
    @(negedge clk);
    irq = 1'b0;
    @(negedge clk); #1;
    check("rst_mid.mem_req_before", BLK_W'(mem_req), BLK_W'(1'b1));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_pulses("rst_mid.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_mid.mem_addr", BLK_W'(mem_addr), '0);
    @(negedge clk);
    mem_rdy = 1'b1; mem_data = {16{8'hA5}};
    #1;
    check("rst_mid.late_l2_rw", BLK_W'(l2_rw), '0);
    check("rst_mid.late_tag_wd", BLK_W'(l2_tag_wd), '0);
    @(negedge clk);
    mem_rdy = 1'b0;
    #1;
    check_pulses("rst_mid.late", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_mid.data_wd_l2", data_wd_l2, '0);

    foreach (vecs[i]) begin
      run_txn(vecs[i], 1'b0, $sformatf("vec%0d", i));
      if (!vecs[i].rw) begin
        if (vecs[i].exp_hit) exp_hits++;
        else                 exp_miss++;
      end
    end

    // Back-to-back: irq held through complete; the next IDLE cycle accepts.
    run_txn(vecs[1], 1'b1, "b2b_first");
    run_txn(vecs[5], 1'b1, "b2b_second");
    exp_hits += 2;
    @(negedge clk);
    irq = 1'b0;
    #1 check("b2b.idle_busy", BLK_W'(l2_busy), '0);
    @(negedge clk); #1;
    check("b2b.stays_idle", BLK_W'(l2_busy), '0);

`ifdef L2_RESP_STAT_EN
    check("stat.hit_cnt", BLK_W'(hit_cnt), BLK_W'(exp_hits));
    check("stat.miss_cnt", BLK_W'(miss_cnt), BLK_W'(exp_miss));
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
